// File: rtl/sram_cell_ctrl_if.sv
// Request/response bus between a host and the single-cell SRAM access controller.
interface sram_cell_ctrl_if;
    logic req;
    logic we;
    logic wdata;
    logic ready;
    logic rvalid;
    logic rdata;
    logic sense_err;
    logic wdone;

    modport master (output req, we, wdata, input ready, rvalid, rdata, sense_err, wdone);
    modport slave  (input req, we, wdata, output ready, rvalid, rdata, sense_err, wdone);
endinterface

// File: rtl/sram_cell_ctrl.sv
// Sequencer for one 6T cell: precharge/sense reads, driven writes, registered outputs.
// Optional post-write read-back check is enabled by defining SRAM_CTRL_WRITE_VERIFY_EN.
module sram_cell_ctrl #(
    parameter int PRECHARGE_CYCLES = 1,
    parameter int WL_CYCLES        = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_cell_ctrl_if.slave   bus,
    output logic              WL,
    inout  wire               BL,
    inout  wire               BR
);
    localparam int MAXC = (PRECHARGE_CYCLES > WL_CYCLES) ? PRECHARGE_CYCLES : WL_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] P_LD = CW'(PRECHARGE_CYCLES - 1);
    localparam logic [CW-1:0] W_LD = CW'(WL_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, PRECH, ACCESS, WRITE, RECOVER
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        , VPRECH, VACCESS
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d, wdata_q, wdata_d, vfy_q, vfy_d;
    logic          ready_q, ready_d, rvalid_q, rvalid_d, wdone_q, wdone_d;
    logic          rdata_q, rdata_d, serr_q, serr_d;
    logic          wl_q, wl_d, drv_q, drv_d, bl_q, bl_d, br_q, br_d;
    logic          accept, cnt_done, bl_bad;

    function automatic logic [CW-1:0] ld_val(state_t s);
        case (s)
            PRECH:   return P_LD;
            ACCESS:  return W_LD;
            WRITE:   return W_LD;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            VPRECH:  return P_LD;
            VACCESS: return W_LD;
`endif
            default: return '0;
        endcase
    endfunction

    assign accept   = (state_q == IDLE) && bus.req;
    assign cnt_done = (cnt_q == '0);
    // Non-complementary or floating bitlines mean the cell did not develop a valid differential.
    assign bl_bad   = (BL === BR) || $isunknown({BL, BR});

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req) state_d = bus.we ? WRITE : PRECH;
            PRECH:   if (cnt_done) state_d = ACCESS;
            ACCESS:  if (cnt_done) state_d = RECOVER;
            WRITE:   if (cnt_done) state_d = RECOVER;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            RECOVER: state_d = (we_q && !vfy_q) ? VPRECH : IDLE;
            VPRECH:  if (cnt_done) state_d = VACCESS;
            VACCESS: if (cnt_done) state_d = RECOVER;
`else
            RECOVER: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q;
        if (state_d != state_q)  cnt_d = ld_val(state_d);
        else if (!cnt_done)      cnt_d = cnt_q - 1'b1;

        we_d    = accept ? bus.we    : we_q;
        wdata_d = accept ? bus.wdata : wdata_q;
        vfy_d   = accept ? 1'b0      : vfy_q;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        if (state_d == VPRECH) vfy_d = 1'b1;
`endif

        ready_d  = (state_d == IDLE);
        rvalid_d = (state_d == RECOVER) && !we_q;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        wdone_d  = (state_d == RECOVER) && we_q && vfy_q;
`else
        wdone_d  = (state_d == RECOVER) && we_q;
`endif

        wl_d  = 1'b0;
        drv_d = 1'b0;
        bl_d  = 1'b1;
        br_d  = 1'b1;
        case (state_d)
            PRECH:   drv_d = 1'b1;
            ACCESS:  wl_d  = 1'b1;
            WRITE: begin
                wl_d  = 1'b1;
                drv_d = 1'b1;
                bl_d  = wdata_d;
                br_d  = ~wdata_d;
            end
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            VPRECH:  drv_d = 1'b1;
            VACCESS: wl_d  = 1'b1;
`endif
            default: ;
        endcase

        rdata_d = rdata_q;
        serr_d  = serr_q;
        if (state_q == ACCESS && cnt_done) begin
            rdata_d = BL;
            serr_d  = bl_bad;
        end
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
        if (state_q == VACCESS && cnt_done) serr_d = bl_bad || (BL !== wdata_q);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= 1'b0;
            vfy_q    <= 1'b0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            rdata_q  <= 1'b0;
            serr_q   <= 1'b0;
            wl_q     <= 1'b0;
            drv_q    <= 1'b0;
            bl_q     <= 1'b0;
            br_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            vfy_q    <= vfy_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            rdata_q  <= rdata_d;
            serr_q   <= serr_d;
            wl_q     <= wl_d;
            drv_q    <= drv_d;
            bl_q     <= bl_d;
            br_q     <= br_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.wdone     = wdone_q;
    assign bus.rdata     = rdata_q;
    assign bus.sense_err = serr_q;
    assign WL            = wl_q;
    assign BL            = drv_q ? bl_q : 1'bz;
    assign BR            = drv_q ? br_q : 1'bz;
endmodule
